// File: rtl/line_xfer_engine.sv
// Cache line transfer engine: one 64-byte fill or writeback at a time, in 8 x 64-bit beats over the arbiter port.
// Optional watchdog enabled by defining LXE_WATCHDOG_EN.
module line_xfer_engine (
  input  logic         clk,
  input  logic         reset,
  input  logic         fill_req,
  input  logic [63:0]  fill_addr,
  input  logic         wb_req,
  input  logic [63:0]  wb_addr,
  input  logic [511:0] wb_data,
  output logic         busy,
  output logic         fill_done,
  output logic [511:0] fill_data,
  output logic         wb_done,
  output logic         xfer_err,
  output logic         reqcyc,
  input  logic         reqack,
  output logic [63:0]  req,
  output logic [12:0]  reqtag,
  input  logic         respcyc,
  input  logic [63:0]  resp,
  input  logic [12:0]  resptag,
  input  logic         writeack
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, WR_WAIT} state_t;

  localparam logic [11:0] TAG_ID    = 12'h100;
  localparam logic [63:0] LINE_MASK = ~64'h3f;

  state_t         state, state_nxt;
  logic [2:0]     beat;
  logic [63:0]    line_addr;
  logic [511:0]   wb_line;
  logic           fill_done_q, wb_done_q;
  logic           wd_expire;

`ifdef LXE_WATCHDOG_EN
  // Counts consecutive cycles waiting on the arbiter; any beat or writeack restarts it.
  logic [9:0] wd_cnt;
  logic       wd_idle;
  logic       xfer_err_q;

  assign wd_idle   = (state == RD_DATA && !respcyc) || (state == WR_WAIT && !writeack);
  assign wd_expire = wd_idle && (wd_cnt == 10'd1023);

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt     <= '0;
      xfer_err_q <= 1'b0;
    end else begin
      xfer_err_q <= wd_expire;
      if (wd_idle && !wd_expire) wd_cnt <= wd_cnt + 10'd1;
      else                       wd_cnt <= '0;
    end
  end

  assign xfer_err = xfer_err_q;
`else
  assign wd_expire = 1'b0;
  assign xfer_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    reqcyc    = 1'b0;
    req       = '0;
    reqtag    = '0;
    case (state)
      IDLE: begin
        if (wb_req)        state_nxt = WR_REQ;
        else if (fill_req) state_nxt = RD_REQ;
      end
      RD_REQ: begin
        reqcyc = 1'b1;
        req    = line_addr;
        reqtag = {1'b1, TAG_ID};
        if (reqack) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        if (wd_expire)                        state_nxt = IDLE;
        else if (respcyc && beat == 3'd7)     state_nxt = IDLE;
      end
      WR_REQ: begin
        reqcyc = 1'b1;
        req    = line_addr;
        reqtag = {1'b0, TAG_ID};
        if (reqack) state_nxt = WR_DATA;
      end
      WR_DATA: begin
        reqcyc = 1'b1;
        req    = wb_line[{beat, 6'b0} +: 64];
        reqtag = {1'b0, TAG_ID};
        if (reqack && beat == 3'd7) state_nxt = WR_WAIT;
      end
      WR_WAIT: begin
        if (wd_expire)     state_nxt = IDLE;
        else if (writeack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request inputs are captured only on leaving IDLE; later changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat        <= '0;
      line_addr   <= '0;
      wb_line     <= '0;
      fill_data   <= '0;
      fill_done_q <= 1'b0;
      wb_done_q   <= 1'b0;
    end else begin
      fill_done_q <= 1'b0;
      wb_done_q   <= 1'b0;
      case (state)
        IDLE: begin
          beat <= '0;
          if (wb_req) begin
            line_addr <= wb_addr & LINE_MASK;
            wb_line   <= wb_data;
          end else if (fill_req) begin
            line_addr <= fill_addr & LINE_MASK;
          end
        end
        RD_DATA: begin
          if (respcyc) begin
            fill_data[{beat, 6'b0} +: 64] <= resp;
            beat <= beat + 3'd1;
            if (beat == 3'd7) fill_done_q <= 1'b1;
          end
        end
        WR_DATA: begin
          if (reqack) beat <= beat + 3'd1;
        end
        WR_WAIT: begin
          if (writeack) wb_done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign fill_done = fill_done_q;
  assign wb_done   = wb_done_q;

  // Read beats must carry this engine's read tag.
  a_resp_tag: assert property (@(posedge clk) disable iff (reset)
    (state == RD_DATA && respcyc) |-> (resptag == {1'b1, TAG_ID}));

endmodule

// File: doc/line_xfer_engine.md
LINE_XFER_ENGINE -- requirements
Module: line_xfer_engine

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- fill_req  in  1  line-fill request, level
- fill_addr  in  64  fill byte address
- wb_req  in  1  writeback request, level
- wb_addr  in  64  writeback byte address
- wb_data  in  512  victim line
- busy  out  1  engine not IDLE
- fill_done  out  1  one-cycle pulse, fill_data valid
- fill_data  out  512  assembled line
- wb_done  out  1  one-cycle pulse, writeback accepted
- xfer_err  out  1  one-cycle pulse, watchdog expiry
- reqcyc  out  1  request valid, toward arbiter cache port
- reqack  in  1  arbiter accepted current request word
- req  out  64  address or write-data beat
- reqtag  out  13  [12]=1 read, 0 write; [11:0]=12'h100
- respcyc  in  1  read beat valid
- resp  in  64  read beat
- resptag  in  13  ignored except by assertions
- writeack  in  1  arbiter write-complete pulse
REQ-002 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-003 SHALL have states IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, WR_WAIT.
REQ-004 SHALL, in IDLE, service wb_req before fill_req when both are high.
REQ-005 SHALL latch address with bits [5:0] forced to 0, and wb_data, on IDLE exit; later input changes are ignored.
REQ-006 SHALL, in RD_REQ, drive reqcyc=1, req=line address, reqtag[12]=1 until reqack=1 is sampled, then drop reqcyc next cycle and enter RD_DATA.
REQ-007 SHALL, in RD_DATA, store beat k (k=0..7, 3-bit counter) into fill_data[64k+63:64k] on each cycle respcyc=1; cycles with respcyc=0 do not advance k.
REQ-008 SHALL, on the 8th beat, pulse fill_done the next cycle with the complete line and return to IDLE; latency from last beat to fill_done is 1 cycle.
REQ-009 SHALL, in WR_REQ, drive reqcyc=1, req=line address, reqtag[12]=0; on reqack=1, enter WR_DATA with beat counter 0.
REQ-010 SHALL, in WR_DATA, present wb_data[64k+63:64k] on req with reqcyc=1, advancing k on each reqack=1; after beat 7 is acked, drop reqcyc and enter WR_WAIT.
REQ-011 SHALL, in WR_WAIT, pulse wb_done one cycle after writeack=1 and return to IDLE.
REQ-012 SHALL treat respcyc outside RD_DATA and writeack outside WR_WAIT as ignored.
REQ-013 SHALL drive busy=1 in every state except IDLE; a request arriving while busy waits; no request is dropped.
REQ-014 SHALL hold fill_data stable from fill_done until the next fill's first beat.
REQ-015 SHALL accept a new request in the cycle following fill_done or wb_done (no dead cycle beyond the return to IDLE).

Reset
REQ-016 SHALL, with reset=1 at a clock edge, enter IDLE, zero the beat counter and watchdog, and drive reqcyc=0, req=0, reqtag=0, busy=0, fill_done=0, wb_done=0, xfer_err=0, fill_data=0.
REQ-017 SHALL abandon any in-flight transfer on reset mid-operation, with no done pulse.

Configuration
REQ-018 SHALL, with LXE_WATCHDOG_EN defined, count cycles in RD_DATA and WR_WAIT, reset on each beat or writeack; at 1024 idle cycles, pulse xfer_err, drop reqcyc, and return to IDLE without fill_done/wb_done.
REQ-019 SHALL, without LXE_WATCHDOG_EN, omit the counter, tie xfer_err to 0, and wait indefinitely.

Verification
REQ-020 fill_addr=64'h1047, reqack after 2 cycles, 8 beats resp=k*64'h11 -> req=64'h1040, tag[12]=1; fill_data[63:0]=0, [511:448]=64'h77; fill_done 1 cycle after beat 8.
REQ-021 wb_req and fill_req same cycle -> write sequence first (8 beats, wb_done after writeack), then fill starts from IDLE.
REQ-022 Read beats with respcyc gaps of 3 cycles between beats -> beat order preserved, exactly one fill_done.
REQ-023 reset asserted after 4th write beat acked -> next cycle reqcyc=0, busy=0, no wb_done.
REQ-024 LXE_WATCHDOG_EN, fill with only 5 beats -> xfer_err at the 1024th idle cycle, busy=0, no fill_done; without the macro, the engine stays busy.
